// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handshakes with the instruction and data memories and gates the decoder's strobes into the datapath.
module multicycle_sequencer #(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  input  logic            dec_RegWEn,
  input  logic            dec_MemRw,
  input  logic            dec_PCSel,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            RegWEn,
  output logic            PCWEn,
  output logic            PCSel,
  output logic            retired,
  output logic [31:0]     instret,
  output logic            bus_err,
  output logic [2:0]      state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  // Eight bits covers the full 1..255 timeout range.
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  logic [2:0]      state_reg, state_next;
  logic [7:0]      wait_cnt_reg, wait_cnt_next;
  logic [XLEN-1:0] instr_reg;
  logic [31:0]     instret_reg;
  logic            bus_err_reg;

  logic wait_expired;
  logic is_mem_op;
  logic is_legal;

  assign wait_expired = (wait_cnt_reg == TIMEOUT_LIM);
  assign is_mem_op    = (instr_reg[6:0] == OP_LOAD) || (instr_reg[6:0] == OP_STORE);
  assign is_legal     = (instr_reg[1:0] == 2'b11);

  // An ack in the cycle the counter hits the limit is checked first, so it wins.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      S_IDLE: begin
        if (run) begin
          state_next    = S_FETCH;
          wait_cnt_next = 8'd0;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          state_next = S_DECODE;
        end else if (wait_expired) begin
          state_next = S_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_DECODE: begin
        state_next = is_legal ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        if (is_mem_op) begin
          state_next    = S_MEM;
          wait_cnt_next = 8'd0;
        end else begin
          state_next = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          state_next = S_WB;
        end else if (wait_expired) begin
          state_next = S_ERR;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
        end
      end
      S_WB: begin
        if (run) begin
          state_next    = S_FETCH;
          wait_cnt_next = 8'd0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_ERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 8'd0;
      instr_reg    <= '0;
      instret_reg  <= 32'd0;
      bus_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (state_reg == S_FETCH && imem_ack) begin
        instr_reg <= imem_rdata;
      end
      if (state_reg == S_WB) begin
        instret_reg <= instret_reg + 32'd1;
      end
      if (state_next == S_ERR) begin
        bus_err_reg <= 1'b1;
      end
    end
  end

  logic in_wb;
  logic in_mem;
  assign in_wb  = (state_reg == S_WB);
  assign in_mem = (state_reg == S_MEM);

  assign imem_req = (state_reg == S_FETCH);
  assign dmem_req = in_mem;
  assign dmem_we  = in_mem & dec_MemRw;
  assign RegWEn   = in_wb & dec_RegWEn;
  assign PCWEn    = in_wb;
  assign PCSel    = in_wb & dec_PCSel;
  assign retired  = in_wb;
  assign instr    = instr_reg;
  assign instret  = instret_reg;
  assign bus_err  = bus_err_reg;
  assign state    = state_reg;

endmodule
